// File: rtl/snitch_perf_counters.sv
// Cluster performance counters: per-hart event strobes counted into programmable counters over a valid/ready register port.
// Optional snapshot registers are built when SNITCH_PERF_SNAPSHOT_EN is defined.
module snitch_perf_counters #(
  parameter int unsigned NumCores     = 8,
  parameter int unsigned NumEvents    = 7,
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned CounterWidth = 32,
  parameter int unsigned AddrWidth    = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumCores*NumEvents-1:0] events_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AddrWidth-1:0]          req_addr_i,
  input  logic                          req_write_i,
  input  logic [31:0]                   req_wdata_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [31:0]                   rsp_rdata_o,
  output logic                          overflow_o
);

  localparam int unsigned IncWidth   = $clog2(NumCores) + 1;
  localparam int unsigned SumWidth   = CounterWidth + IncWidth;
  localparam int unsigned GlobalAddr = 2 * NumCounters;
  localparam int unsigned SnapBase   = 2 * NumCounters + 1;

  logic [NumCores*NumEvents-1:0] events_q;
  logic [NumCounters-1:0]        en_q, all_q, ovf_q;
  logic [7:0]                    hart_sel_q  [NumCounters];
  logic [3:0]                    event_sel_q [NumCounters];
  logic [CounterWidth-1:0]       value_q     [NumCounters];

  logic [IncWidth-1:0]    inc   [NumCounters];
  logic [SumWidth-1:0]    sum   [NumCounters];
  logic [NumCounters-1:0] carry;
  logic [NumCounters-1:0] ctrl_wr, val_wr;
  logic                   accept, wr, clear_all;
  logic [31:0]            addr, rdata;

  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign wr          = accept && req_write_i;
  assign addr        = 32'(req_addr_i);
  assign clear_all   = wr && (addr == GlobalAddr) && req_wdata_i[0];

  // Single-hart mode is the all-harts sum restricted to one hart; out-of-range selects match nothing.
  always_comb begin
    for (int unsigned c = 0; c < NumCounters; c++) begin
      inc[c] = '0;
      for (int unsigned h = 0; h < NumCores; h++) begin
        for (int unsigned e = 0; e < NumEvents; e++) begin
          if (32'(event_sel_q[c]) == e && (all_q[c] || 32'(hart_sel_q[c]) == h)) begin
            inc[c] = inc[c] + IncWidth'(events_q[h*NumEvents+e]);
          end
        end
      end
      if (!en_q[c]) inc[c] = '0;
      sum[c]   = SumWidth'(value_q[c]) + SumWidth'(inc[c]);
      carry[c] = |sum[c][SumWidth-1:CounterWidth];
    end
  end

  always_comb begin
    ctrl_wr = '0;
    val_wr  = '0;
    for (int unsigned c = 0; c < NumCounters; c++) begin
      ctrl_wr[c] = wr && (addr == 2*c);
      val_wr[c]  = wr && (addr == 2*c + 1);
    end
  end

`ifdef SNITCH_PERF_SNAPSHOT_EN
  logic [CounterWidth-1:0] snap_q [NumCounters];
  logic                    snapshot;

  assign snapshot = wr && (addr == GlobalAddr) && req_wdata_i[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NumCounters; c++) snap_q[c] <= '0;
    end else if (snapshot) begin
      for (int unsigned c = 0; c < NumCounters; c++) snap_q[c] <= value_q[c];
    end
  end
`endif

  always_comb begin
    rdata = '0;
    for (int unsigned c = 0; c < NumCounters; c++) begin
      if (addr == 2*c) begin
        rdata = {12'd0, event_sel_q[c], 4'd0, hart_sel_q[c], 1'b0, ovf_q[c], all_q[c], en_q[c]};
      end
      if (addr == 2*c + 1) rdata = 32'(value_q[c]);
`ifdef SNITCH_PERF_SNAPSHOT_EN
      if (addr == SnapBase + c) rdata = 32'(snap_q[c]);
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      events_q <= '0;
      en_q     <= '0;
      all_q    <= '0;
      ovf_q    <= '0;
      for (int unsigned c = 0; c < NumCounters; c++) begin
        hart_sel_q[c]  <= '0;
        event_sel_q[c] <= '0;
        value_q[c]     <= '0;
      end
    end else begin
      events_q <= events_i;
      for (int unsigned c = 0; c < NumCounters; c++) begin
        if (ctrl_wr[c]) begin
          en_q[c]        <= req_wdata_i[0];
          all_q[c]       <= req_wdata_i[1];
          hart_sel_q[c]  <= req_wdata_i[11:4];
          event_sel_q[c] <= req_wdata_i[19:16];
        end
        if (clear_all) begin
          value_q[c] <= '0;
          ovf_q[c]   <= 1'b0;
        end else begin
          if (val_wr[c]) value_q[c] <= req_wdata_i[CounterWidth-1:0];
          else           value_q[c] <= sum[c][CounterWidth-1:0];
          // A fresh overflow beats a simultaneous write-1-to-clear.
          if (carry[c] && !val_wr[c])            ovf_q[c] <= 1'b1;
          else if (ctrl_wr[c] && req_wdata_i[2]) ovf_q[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      overflow_o  <= 1'b0;
    end else begin
      overflow_o <= |ovf_q;
      if (accept) begin
        rsp_valid_o <= 1'b1;
        rsp_rdata_o <= req_write_i ? 32'd0 : rdata;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snitch_perf_counters.sv
// Scoreboard bench for snitch_perf_counters: expected responses queued at acceptance, checked when delivered.
module tb_snitch_perf_counters;

  localparam int unsigned NC = 8;
  localparam int unsigned NE = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC*NE-1:0]  events;
  logic              req_valid, req_ready, req_write;
  logic [7:0]        req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              overflow;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  always #5 clk = ~clk;

  snitch_perf_counters #(
    .NumCores(NC), .NumEvents(NE), .NumCounters(4), .CounterWidth(32), .AddrWidth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .events_i(events),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .overflow_o(overflow)
  );

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got %h, no response expected", rsp_rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (rsp_rdata !== mon_exp) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", mon_name, rsp_rdata, mon_exp);
        end
      end
    end
  end

  task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string name);
    int unsigned n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 50) begin n++; @(negedge clk); end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL %s_accept: req_ready low, expected 1 within 50 cycles", name);
    end else begin
      exp_q.push_back(w ? 32'h0 : exp);
      name_q.push_back(name);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string name);
    access(1'b1, a, d, 32'h0, name);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    access(1'b0, a, 32'h0, exp, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks += 4;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b, expected 0", rsp_valid); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b, expected 1", req_ready); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_overflow: got %b, expected 0", overflow); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h, expected 0", rsp_rdata); end
    for (int i = 0; i < 8; i++) rd(8'(i), 32'h0, $sformatf("rst_word%0d", i));
    rd(8'd8, 32'h0, "global_reads_zero");
    wr(8'd63, 32'hFFFF_FFFF, "w_unmapped");
    rd(8'd63, 32'h0, "unmapped_reads_zero");
    drain();
  endtask

  task automatic test_single_hart();
    wr(8'd0, 32'h0003_0031, "w_ctrl0");
    events = '0; events[3*NE+3] = 1'b1; idle(10);
    events = '0; events[2*NE+3] = 1'b1; idle(5);
    events = '0; idle(3);
    rd(8'd1, 32'd10, "value0_single_hart");
    wr(8'd0, 32'h0003_0030, "w_ctrl0_disable");
    rd(8'd0, 32'h0003_0030, "ctrl0_readback");
    drain();
  endtask

  task automatic test_all_harts();
    wr(8'd2, 32'h3, "w_ctrl1");
    events = '0;
    for (int h = 0; h < NC; h++) events[h*NE] = 1'b1;
    idle(4);
    events = '0; idle(3);
    rd(8'd3, 32'd32, "value1_all_harts");
    wr(8'd2, 32'h2, "w_ctrl1_disable");
    rd(8'd2, 32'h2, "ctrl1_readback");
    drain();
  endtask

  task automatic test_wrap_overflow();
    wr(8'd5, 32'hFFFF_FFFE, "w_value2");
    wr(8'd4, 32'h3, "w_ctrl2");
    events = '0; events[0] = 1'b1; events[NE] = 1'b1; events[2*NE] = 1'b1;
    idle(1);
    events = '0; idle(3);
    rd(8'd5, 32'h1, "value2_wrapped");
    rd(8'd4, 32'h7, "ctrl2_sticky_set");
    drain();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b, expected 1", overflow); end
    wr(8'd4, 32'h3, "w_ctrl2_bit2_zero");
    rd(8'd4, 32'h7, "ctrl2_sticky_kept");
    wr(8'd5, 32'hFFFF_FFFF, "w_value2_max");
    events = '0; events[0] = 1'b1;
    idle(1);
    wr(8'd4, 32'h7, "w_ctrl2_w1c_collide");
    events = '0; idle(2);
    rd(8'd4, 32'h7, "ctrl2_set_beats_w1c");
    rd(8'd5, 32'h1, "value2_after_collide");
    wr(8'd4, 32'h6, "w_ctrl2_w1c");
    rd(8'd4, 32'h2, "ctrl2_sticky_cleared");
    drain();
    idle(2);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_cleared: got %b, expected 0", overflow); end
  endtask

  task automatic test_priority();
    wr(8'd6, 32'h3, "w_ctrl3");
    events = '0;
    for (int h = 0; h < NC; h++) events[h*NE] = 1'b1;
    idle(1);
    events = '0;
    wr(8'd7, 32'h100, "w_value3_collide");
    idle(2);
    rd(8'd7, 32'h100, "value3_write_beats_inc");
    wr(8'd8, 32'h1, "w_clear_all");
    for (int i = 0; i < 4; i++) rd(8'(2*i+1), 32'h0, $sformatf("value%0d_cleared", i));
    rd(8'd0, 32'h0003_0030, "ctrl0_kept");
    rd(8'd2, 32'h2, "ctrl1_kept");
    rd(8'd4, 32'h2, "ctrl2_kept");
    rd(8'd6, 32'h3, "ctrl3_kept");
    drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    rd(8'd0, 32'h0003_0030, "b2b_ctrl0");
    rd(8'd2, 32'h2, "b2b_ctrl1");
    rd(8'd4, 32'h2, "b2b_ctrl2");
    rd(8'd6, 32'h3, "b2b_ctrl3");
    checks++;
    if ($time - t0 != 40) begin errors++; $display("FAIL b2b_throughput: took %0t, expected 40", $time - t0); end
    drain();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    rd(8'd6, 32'h3, "ctrl3_stalled");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks += 3;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b, expected 0", req_ready); end
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b, expected 1", rsp_valid); end
      if (rsp_rdata !== 32'h3) begin errors++; $display("FAIL bp_rdata_stable: got %h, expected 3", rsp_rdata); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
  endtask

  task automatic test_snapshot();
    wr(8'd7, 32'h42, "w_value3_42");
    wr(8'd8, 32'h2, "w_snapshot");
    events = '0; events[0] = 1'b1; idle(5);
    events = '0; idle(3);
`ifdef SNITCH_PERF_SNAPSHOT_EN
    rd(8'd12, 32'h42, "snap3");
    rd(8'd7, 32'h47, "value3_after_snap");
    wr(8'd8, 32'h1, "w_clear_all_snap");
    rd(8'd12, 32'h42, "snap3_survives_clear");
    rd(8'd7, 32'h0, "value3_cleared");
`else
    rd(8'd12, 32'h0, "snap3_absent");
    rd(8'd7, 32'h47, "value3_after_snap");
`endif
    drain();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    rd(8'd6, 32'h3, "ctrl3_dropped");
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_drops_rsp: got %b, expected 0", rsp_valid); end
    exp_q.delete();
    name_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    idle(2);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL no_rsp_after_reset: got %b, expected 0", rsp_valid); end
    rd(8'd6, 32'h0, "ctrl3_after_reset");
    rd(8'd7, 32'h0, "value3_after_reset");
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; events = '0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single_hart();
    test_all_harts();
    test_wrap_overflow();
    test_priority();
    test_back_to_back();
    test_backpressure();
    test_snapshot();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
